// File: rtl/lc3_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_control_fsm_if
//  Description : Control bundle between the LC-3 control FSM and its datapath.
//                The control side takes the master modport and the datapath
//                takes the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lc3_control_fsm_if;
    // Datapath status into the controller
    logic [15:0] i_IR;
    logic        i_Ready_Bit;
    logic [2:0]  i_NZP;

    // Register load enables
    logic        o_LD_MAR;
    logic        o_LD_MDR;
    logic        o_LD_IR;
    logic        o_LD_REG;
    logic        o_LD_CC;
    logic        o_LD_PC;

    // Bus drivers, one-hot or idle
    logic        o_GatePC;
    logic        o_GateMDR;
    logic        o_GateALU;
    logic        o_GateMarMux;

    // Mux selects and ALU function
    logic [1:0]  o_PCMUX;
    logic [1:0]  o_DRMUX;
    logic [1:0]  o_SR1MUX;
    logic        o_ADDR1MUX;
    logic [1:0]  o_ADDR2MUX;
    logic        o_MARMUX;
    logic [1:0]  o_ALUK;
    logic        o_SR2MUX;

    // Memory strobes and status
    logic        o_MEM_EN;
    logic        o_R_W;
    logic [3:0]  o_state;
    logic        o_halted;

    modport master (
        input  i_IR, i_Ready_Bit, i_NZP,
        output o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_REG, o_LD_CC, o_LD_PC,
        output o_GatePC, o_GateMDR, o_GateALU, o_GateMarMux,
        output o_PCMUX, o_DRMUX, o_SR1MUX, o_ADDR1MUX, o_ADDR2MUX,
        output o_MARMUX, o_ALUK, o_SR2MUX,
        output o_MEM_EN, o_R_W, o_state, o_halted
    );

    modport slave (
        output i_IR, i_Ready_Bit, i_NZP,
        input  o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_REG, o_LD_CC, o_LD_PC,
        input  o_GatePC, o_GateMDR, o_GateALU, o_GateMarMux,
        input  o_PCMUX, o_DRMUX, o_SR1MUX, o_ADDR1MUX, o_ADDR2MUX,
        input  o_MARMUX, o_ALUK, o_SR2MUX,
        input  o_MEM_EN, o_R_W, o_state, o_halted
    );
endinterface
`default_nettype wire

// File: rtl/lc3_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_control_fsm
//  Description : Moore control state machine for a reduced LC-3 datapath.
//                Outputs depend only on the registered state and IR fields;
//                every output is held at zero while rst is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_control_fsm (
    input  logic               clk,
    input  logic               rst,
    lc3_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH0   = 4'd0,
        S_FETCH1   = 4'd1,
        S_FETCH2   = 4'd2,
        S_DECODE   = 4'd3,
        S_ALU      = 4'd4,
        S_LEA      = 4'd5,
        S_BR_TAKE  = 4'd6,
        S_JMP      = 4'd7,
        S_JSR0     = 4'd8,
        S_JSR1     = 4'd9,
        S_MEM_ADDR = 4'd10,
        S_LD_READ  = 4'd11,
        S_LD_WB    = 4'd12,
        S_ST_DATA  = 4'd13,
        S_ST_WRITE = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  w_opcode;
    logic        w_ben;
    logic        w_unused_ir;

    logic        w_ld_mar, w_ld_mdr, w_ld_ir, w_ld_reg, w_ld_cc, w_ld_pc;
    logic        w_gate_pc, w_gate_mdr, w_gate_alu, w_gate_marmux;
    logic [1:0]  w_pcmux, w_drmux, w_sr1mux, w_addr2mux, w_aluk;
    logic        w_addr1mux, w_marmux, w_sr2mux;
    logic        w_mem_en, w_r_w, w_halted;

    assign w_opcode = bus.i_IR[15:12];

    // Branch enable: any condition code selected by IR[11:9] that is set
    assign w_ben = (bus.i_IR[11] & bus.i_NZP[2])
                 | (bus.i_IR[10] & bus.i_NZP[1])
                 | (bus.i_IR[9]  & bus.i_NZP[0]);

    // Register-select and immediate bits are consumed by the datapath only
    assign w_unused_ir = ^{bus.i_IR[8:6], bus.i_IR[4:0]};

    // State register, asynchronously returned to FETCH0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and Moore output decode
    always_comb begin
        w_next        = r_state;
        w_ld_mar      = 1'b0;
        w_ld_mdr      = 1'b0;
        w_ld_ir       = 1'b0;
        w_ld_reg      = 1'b0;
        w_ld_cc       = 1'b0;
        w_ld_pc       = 1'b0;
        w_gate_pc     = 1'b0;
        w_gate_mdr    = 1'b0;
        w_gate_alu    = 1'b0;
        w_gate_marmux = 1'b0;
        w_pcmux       = 2'b00;
        w_drmux       = 2'b00;
        w_sr1mux      = 2'b00;
        w_addr1mux    = 1'b0;
        w_addr2mux    = 2'b00;
        w_marmux      = 1'b0;
        w_aluk        = 2'b00;
        w_sr2mux      = 1'b0;
        w_mem_en      = 1'b0;
        w_r_w         = 1'b0;
        w_halted      = 1'b0;

        case (r_state)
            S_FETCH0: begin
                w_gate_pc = 1'b1;
                w_ld_mar  = 1'b1;
                w_ld_pc   = 1'b1;
                w_next    = S_FETCH1;
            end
            S_FETCH1: begin
                w_mem_en = 1'b1;
                w_ld_mdr = 1'b1;
                if (bus.i_Ready_Bit) begin
                    w_next = S_FETCH2;
                end
            end
            S_FETCH2: begin
                w_gate_mdr = 1'b1;
                w_ld_ir    = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                case (w_opcode)
                    4'b0001, 4'b0101, 4'b1001: w_next = S_ALU;
                    4'b1110:                   w_next = S_LEA;
                    4'b0000:                   w_next = w_ben ? S_BR_TAKE : S_FETCH0;
                    4'b1100:                   w_next = S_JMP;
                    4'b0100:                   w_next = S_JSR0;
                    4'b0010, 4'b0110,
                    4'b0011, 4'b0111:          w_next = S_MEM_ADDR;
                    default:                   w_next = S_HALT;
                endcase
            end
            S_ALU: begin
                w_gate_alu = 1'b1;
                w_ld_reg   = 1'b1;
                w_ld_cc    = 1'b1;
                w_sr1mux   = 2'b01;
                w_sr2mux   = bus.i_IR[5];
                case (w_opcode)
                    4'b0101: w_aluk = 2'b01;
                    4'b1001: w_aluk = 2'b10;
                    default: w_aluk = 2'b00;
                endcase
                w_next = S_FETCH0;
            end
            S_LEA: begin
                w_addr2mux    = 2'b10;
                w_marmux      = 1'b1;
                w_gate_marmux = 1'b1;
                w_ld_reg      = 1'b1;
                w_next        = S_FETCH0;
            end
            S_BR_TAKE: begin
                w_addr2mux = 2'b10;
                w_pcmux    = 2'b10;
                w_ld_pc    = 1'b1;
                w_next     = S_FETCH0;
            end
            S_JMP: begin
                w_sr1mux   = 2'b01;
                w_addr1mux = 1'b1;
                w_pcmux    = 2'b10;
                w_ld_pc    = 1'b1;
                w_next     = S_FETCH0;
            end
            S_JSR0: begin
                // Return address goes to R7 before the PC is redirected
                w_gate_pc = 1'b1;
                w_ld_reg  = 1'b1;
                w_drmux   = 2'b01;
                w_next    = S_JSR1;
            end
            S_JSR1: begin
                // JSRR through R7 sees the freshly written return address
                w_pcmux = 2'b10;
                w_ld_pc = 1'b1;
                if (bus.i_IR[11]) begin
                    w_addr2mux = 2'b11;
                end else begin
                    w_addr1mux = 1'b1;
                    w_sr1mux   = 2'b01;
                end
                w_next = S_FETCH0;
            end
            S_MEM_ADDR: begin
                // IR[14] separates base+offset6 (LDR/STR) from PC+offset9
                w_marmux      = 1'b1;
                w_gate_marmux = 1'b1;
                w_ld_mar      = 1'b1;
                w_sr1mux      = 2'b01;
                w_addr1mux    = bus.i_IR[14];
                w_addr2mux    = bus.i_IR[14] ? 2'b01 : 2'b10;
                w_next        = bus.i_IR[12] ? S_ST_DATA : S_LD_READ;
            end
            S_LD_READ: begin
                w_mem_en = 1'b1;
                w_ld_mdr = 1'b1;
                if (bus.i_Ready_Bit) begin
                    w_next = S_LD_WB;
                end
            end
            S_LD_WB: begin
                w_gate_mdr = 1'b1;
                w_ld_reg   = 1'b1;
                w_ld_cc    = 1'b1;
                w_next     = S_FETCH0;
            end
            S_ST_DATA: begin
                // Source register passes through the ALU onto the bus into MDR
                w_aluk     = 2'b11;
                w_gate_alu = 1'b1;
                w_ld_mdr   = 1'b1;
                w_next     = S_ST_WRITE;
            end
            S_ST_WRITE: begin
                w_mem_en = 1'b1;
                w_r_w    = 1'b1;
                if (bus.i_Ready_Bit) begin
                    w_next = S_FETCH0;
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
        endcase
    end

    // All outputs are squashed while reset is asserted
    assign bus.o_LD_MAR     = rst & w_ld_mar;
    assign bus.o_LD_MDR     = rst & w_ld_mdr;
    assign bus.o_LD_IR      = rst & w_ld_ir;
    assign bus.o_LD_REG     = rst & w_ld_reg;
    assign bus.o_LD_CC      = rst & w_ld_cc;
    assign bus.o_LD_PC      = rst & w_ld_pc;
    assign bus.o_GatePC     = rst & w_gate_pc;
    assign bus.o_GateMDR    = rst & w_gate_mdr;
    assign bus.o_GateALU    = rst & w_gate_alu;
    assign bus.o_GateMarMux = rst & w_gate_marmux;
    assign bus.o_PCMUX      = rst ? w_pcmux    : 2'b00;
    assign bus.o_DRMUX      = rst ? w_drmux    : 2'b00;
    assign bus.o_SR1MUX     = rst ? w_sr1mux   : 2'b00;
    assign bus.o_ADDR1MUX   = rst & w_addr1mux;
    assign bus.o_ADDR2MUX   = rst ? w_addr2mux : 2'b00;
    assign bus.o_MARMUX     = rst & w_marmux;
    assign bus.o_ALUK       = rst ? w_aluk     : 2'b00;
    assign bus.o_SR2MUX     = rst & w_sr2mux;
    assign bus.o_MEM_EN     = rst & w_mem_en;
    assign bus.o_R_W        = rst & w_r_w;
    assign bus.o_state      = rst ? r_state    : 4'd0;
    assign bus.o_halted     = rst & w_halted;

endmodule
`default_nettype wire

// File: tb/tb_lc3_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_control_fsm
//  Description : Directed, table-driven bench for the LC-3 control FSM with
//                hand-written sequences for memory waits, HALT and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_control_fsm;

    // Expected-output bit layout, MSB first:
    // LD_MAR LD_MDR LD_IR LD_REG LD_CC LD_PC GatePC GateMDR GateALU GateMarMux
    // PCMUX[1:0] DRMUX[1:0] SR1MUX[1:0] ADDR1MUX ADDR2MUX[1:0] MARMUX ALUK[1:0]
    // SR2MUX MEM_EN R_W halted
    localparam logic [25:0] E_LD_MAR   = 26'(1) << 25;
    localparam logic [25:0] E_LD_MDR   = 26'(1) << 24;
    localparam logic [25:0] E_LD_IR    = 26'(1) << 23;
    localparam logic [25:0] E_LD_REG   = 26'(1) << 22;
    localparam logic [25:0] E_LD_CC    = 26'(1) << 21;
    localparam logic [25:0] E_LD_PC    = 26'(1) << 20;
    localparam logic [25:0] E_G_PC     = 26'(1) << 19;
    localparam logic [25:0] E_G_MDR    = 26'(1) << 18;
    localparam logic [25:0] E_G_ALU    = 26'(1) << 17;
    localparam logic [25:0] E_G_MARMUX = 26'(1) << 16;
    localparam logic [25:0] E_PC_ADDER = 26'(2) << 14;
    localparam logic [25:0] E_DR_R7    = 26'(1) << 12;
    localparam logic [25:0] E_SR1_86   = 26'(1) << 10;
    localparam logic [25:0] E_A1_SR1   = 26'(1) << 9;
    localparam logic [25:0] E_A2_OFF6  = 26'(1) << 7;
    localparam logic [25:0] E_A2_OFF9  = 26'(2) << 7;
    localparam logic [25:0] E_A2_OFF11 = 26'(3) << 7;
    localparam logic [25:0] E_MAR_ADD  = 26'(1) << 6;
    localparam logic [25:0] E_ALU_AND  = 26'(1) << 4;
    localparam logic [25:0] E_ALU_NOT  = 26'(2) << 4;
    localparam logic [25:0] E_ALU_PASS = 26'(3) << 4;
    localparam logic [25:0] E_SR2_IMM  = 26'(1) << 3;
    localparam logic [25:0] E_MEM_EN   = 26'(1) << 2;
    localparam logic [25:0] E_R_W      = 26'(1) << 1;
    localparam logic [25:0] E_HALTED   = 26'(1);

    localparam logic [25:0] E_FETCH0 = E_G_PC | E_LD_MAR | E_LD_PC;
    localparam logic [25:0] E_FETCH1 = E_MEM_EN | E_LD_MDR;
    localparam logic [25:0] E_FETCH2 = E_G_MDR | E_LD_IR;

    typedef struct {
        string              name;
        logic [15:0]        ir;
        logic [2:0]         nzp;
        int                 n;
        logic [2:0][3:0]    st;
        logic [2:0][25:0]   ov;
    } vec_t;

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_errors;
    vec_t        tbl [$];
    logic [25:0] w_out;
    int          w_gates;

    lc3_control_fsm_if bus ();

    lc3_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign w_out = {bus.o_LD_MAR, bus.o_LD_MDR, bus.o_LD_IR, bus.o_LD_REG,
                    bus.o_LD_CC, bus.o_LD_PC, bus.o_GatePC, bus.o_GateMDR,
                    bus.o_GateALU, bus.o_GateMarMux, bus.o_PCMUX, bus.o_DRMUX,
                    bus.o_SR1MUX, bus.o_ADDR1MUX, bus.o_ADDR2MUX, bus.o_MARMUX,
                    bus.o_ALUK, bus.o_SR2MUX, bus.o_MEM_EN, bus.o_R_W,
                    bus.o_halted};

    assign w_gates = int'(bus.o_GatePC) + int'(bus.o_GateMDR)
                   + int'(bus.o_GateALU) + int'(bus.o_GateMarMux);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [3:0] st, input logic [25:0] ov);
        check({name, " state"}, 26'(bus.o_state), 26'(st));
        check({name, " outs"}, w_out, ov);
    endtask

    // Bus and memory-strobe invariants on every clock while running
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("one_gate", 26'(w_gates > 1), 26'(0));
            check("mdr_vs_mem",
                  26'(bus.o_LD_MDR && bus.o_MEM_EN && bus.o_state != 4'd1 && bus.o_state != 4'd11),
                  26'(0));
        end
    end

    task automatic add_row(input string name, input logic [15:0] ir, input logic [2:0] nzp,
                           input int n,
                           input logic [3:0] s0, input logic [25:0] o0,
                           input logic [3:0] s1, input logic [25:0] o1,
                           input logic [3:0] s2, input logic [25:0] o2);
        vec_t v;
        v.name = name; v.ir = ir; v.nzp = nzp; v.n = n;
        v.st[0] = s0; v.st[1] = s1; v.st[2] = s2;
        v.ov[0] = o0; v.ov[1] = o1; v.ov[2] = o2;
        tbl.push_back(v);
    endtask

    // Assert reset across a few clocks, then release on a falling edge
    task automatic do_reset();
        rst = 1'b0;
        #1;
        expect_state("rst_async", 4'd0, 26'd0);
        repeat (2) step();
        expect_state("rst_held", 4'd0, 26'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_state("rst_release_fetch0", 4'd0, E_FETCH0);
    endtask

    // Fetch/decode an instruction from FETCH0, optionally stalling FETCH1
    task automatic fetch(input string name, input logic [15:0] ir, input logic [2:0] nzp,
                         input bit stall);
        expect_state({name, " f0"}, 4'd0, E_FETCH0);
        bus.i_IR  = ir;
        bus.i_NZP = nzp;
        step();
        expect_state({name, " f1"}, 4'd1, E_FETCH1);
        if (stall) begin
            bus.i_Ready_Bit = 1'b0;
            step();
            expect_state({name, " f1_wait"}, 4'd1, E_FETCH1);
            bus.i_Ready_Bit = 1'b1;
        end
        step();
        expect_state({name, " f2"}, 4'd2, E_FETCH2);
        step();
        expect_state({name, " dec"}, 4'd3, 26'd0);
    endtask

    task automatic run_row(input int idx, input bit stall);
        vec_t v;
        v = tbl[idx];
        fetch(v.name, v.ir, v.nzp, stall);
        for (int k = 0; k < v.n; k++) begin
            step();
            expect_state(v.name, v.st[k], v.ov[k]);
        end
        step();
        check({v.name, " back_f0"}, 26'(bus.o_state), 26'(0));
    endtask

    task automatic run_halt(input string name, input logic [15:0] ir, input int cycles);
        fetch(name, ir, 3'b000, 1'b0);
        for (int k = 0; k < cycles; k++) begin
            step();
            expect_state(name, 4'd15, E_HALTED);
        end
        #2;
        rst = 1'b0;
        #1;
        expect_state({name, " rst_in_halt"}, 4'd0, 26'd0);
        do_reset();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.i_IR = 16'h0000;
        bus.i_NZP = 3'b000;
        bus.i_Ready_Bit = 1'b1;

        add_row("add_imm", 16'h1261, 3'b000, 1,
                4'd4, E_G_ALU | E_LD_REG | E_LD_CC | E_SR1_86 | E_SR2_IMM, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("and_reg", 16'h5042, 3'b000, 1,
                4'd4, E_G_ALU | E_LD_REG | E_LD_CC | E_SR1_86 | E_ALU_AND, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("not", 16'h927F, 3'b000, 1,
                4'd4, E_G_ALU | E_LD_REG | E_LD_CC | E_SR1_86 | E_ALU_NOT | E_SR2_IMM,
                4'd0, 26'd0, 4'd0, 26'd0);
        add_row("lea", 16'hE005, 3'b000, 1,
                4'd5, E_A2_OFF9 | E_MAR_ADD | E_G_MARMUX | E_LD_REG, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("brnp_n", 16'h0A05, 3'b100, 1,
                4'd6, E_A2_OFF9 | E_PC_ADDER | E_LD_PC, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("brnp_z_not", 16'h0A05, 3'b010, 0,
                4'd0, 26'd0, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("brz_z", 16'h0405, 3'b010, 1,
                4'd6, E_A2_OFF9 | E_PC_ADDER | E_LD_PC, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("brz_p_not", 16'h0405, 3'b001, 0,
                4'd0, 26'd0, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("jmp", 16'hC1C0, 3'b000, 1,
                4'd7, E_SR1_86 | E_A1_SR1 | E_PC_ADDER | E_LD_PC, 4'd0, 26'd0, 4'd0, 26'd0);
        add_row("jsr", 16'h4805, 3'b000, 2,
                4'd8, E_G_PC | E_LD_REG | E_DR_R7,
                4'd9, E_PC_ADDER | E_LD_PC | E_A2_OFF11, 4'd0, 26'd0);
        add_row("jsrr", 16'h4080, 3'b000, 2,
                4'd8, E_G_PC | E_LD_REG | E_DR_R7,
                4'd9, E_PC_ADDER | E_LD_PC | E_A1_SR1 | E_SR1_86, 4'd0, 26'd0);
        add_row("ld", 16'h2205, 3'b000, 3,
                4'd10, E_MAR_ADD | E_G_MARMUX | E_LD_MAR | E_SR1_86 | E_A2_OFF9,
                4'd11, E_MEM_EN | E_LD_MDR,
                4'd12, E_G_MDR | E_LD_REG | E_LD_CC);
        add_row("ldr", 16'h6283, 3'b000, 3,
                4'd10, E_MAR_ADD | E_G_MARMUX | E_LD_MAR | E_SR1_86 | E_A1_SR1 | E_A2_OFF6,
                4'd11, E_MEM_EN | E_LD_MDR,
                4'd12, E_G_MDR | E_LD_REG | E_LD_CC);
        add_row("st", 16'h3003, 3'b000, 3,
                4'd10, E_MAR_ADD | E_G_MARMUX | E_LD_MAR | E_SR1_86 | E_A2_OFF9,
                4'd13, E_ALU_PASS | E_G_ALU | E_LD_MDR,
                4'd14, E_MEM_EN | E_R_W);
        add_row("str", 16'h7283, 3'b000, 3,
                4'd10, E_MAR_ADD | E_G_MARMUX | E_LD_MAR | E_SR1_86 | E_A1_SR1 | E_A2_OFF6,
                4'd13, E_ALU_PASS | E_G_ALU | E_LD_MDR,
                4'd14, E_MEM_EN | E_R_W);

        // Reset with the clock running, then the fetch sequence
        #3;
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(i, 1'b0);
        end

        // Store with a three-cycle memory wait in ST_WRITE
        fetch("st_wait", 16'h3003, 3'b000, 1'b0);
        step();
        expect_state("st_wait ma", 4'd10, E_MAR_ADD | E_G_MARMUX | E_LD_MAR | E_SR1_86 | E_A2_OFF9);
        step();
        expect_state("st_wait data", 4'd13, E_ALU_PASS | E_G_ALU | E_LD_MDR);
        step();
        bus.i_Ready_Bit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_state("st_wait hold", 4'd14, E_MEM_EN | E_R_W);
            step();
        end
        expect_state("st_wait last", 4'd14, E_MEM_EN | E_R_W);
        bus.i_Ready_Bit = 1'b1;
        step();
        expect_state("st_wait done", 4'd0, E_FETCH0);

        // Load stalled in LD_READ, then reset asserted mid-wait
        fetch("ld_wait", 16'h2205, 3'b000, 1'b0);
        step();
        step();
        bus.i_Ready_Bit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            expect_state("ld_wait hold", 4'd11, E_MEM_EN | E_LD_MDR);
            step();
        end
        #2;
        rst = 1'b0;
        #1;
        expect_state("ld_wait rst", 4'd0, 26'd0);
        bus.i_Ready_Bit = 1'b1;
        do_reset();

        // Unimplemented opcodes halt until reset
        run_halt("halt_d000", 16'hD000, 20);
        run_halt("halt_trap", 16'hF025, 2);
        run_halt("halt_rti", 16'h8000, 2);

        // Pseudo-random instruction stream with occasional fetch stalls
        for (int i = 0; i < 40; i++) begin
            run_row(int'($urandom_range(0, tbl.size() - 1)), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
